// File: rtl/counter_arbiter.sv
// Round-robin arbiter sharing one CW-bit up-counter among NREQ requesters, one burst at a time.
// Grant visible 1 cycle after req; burst lasts len+1 RUN cycles plus 1 DONE; no backpressure, clr aborts.
module counter_arbiter #(
  parameter int NREQ = 2,
  parameter int CW   = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NREQ-1:0]    req,
  input  logic [NREQ*CW-1:0] len,
  input  logic               clr,
  output logic [NREQ-1:0]    gnt,
  output logic [CW-1:0]      count,
  output logic               busy,
  output logic               done
);

  localparam int IW = $clog2(NREQ);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t            r_state, w_state_nxt;
  logic [IW-1:0]     r_last, w_last_nxt;
  logic [CW-1:0]     r_len_q, w_len_nxt;
  logic [CW-1:0]     r_count, w_count_nxt;
  logic [NREQ-1:0]   r_gnt, w_gnt_nxt;
  logic              r_busy, w_busy_nxt;
  logic              r_done, w_done_nxt;

  logic              w_found;
  logic [IW-1:0]     w_win;
  logic [IW-1:0]     w_idx;

  // Search order starts just past the previous owner and wraps modulo NREQ.
  always_comb begin
    w_found = 1'b0;
    w_win   = r_last;
    w_idx   = r_last;
    for (int i = 1; i <= NREQ; i++) begin
      w_idx = IW'((int'(r_last) + i) % NREQ);
      if (!w_found && req[w_idx]) begin
        w_found = 1'b1;
        w_win   = w_idx;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
      r_last  <= IW'(NREQ - 1);
      r_len_q <= '0;
      r_count <= '0;
      r_gnt   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_last  <= w_last_nxt;
      r_len_q <= w_len_nxt;
      r_count <= w_count_nxt;
      r_gnt   <= w_gnt_nxt;
      r_busy  <= w_busy_nxt;
      r_done  <= w_done_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_last_nxt  = r_last;
    w_len_nxt   = r_len_q;
    w_count_nxt = r_count;
    w_gnt_nxt   = r_gnt;
    w_busy_nxt  = r_busy;
    w_done_nxt  = 1'b0;
    case (r_state)
      IDLE: begin
        w_gnt_nxt   = '0;
        w_count_nxt = '0;
        w_busy_nxt  = 1'b0;
        if (w_found) begin
          w_state_nxt      = RUN;
          w_gnt_nxt[w_win] = 1'b1;
          w_busy_nxt       = 1'b1;
          w_len_nxt        = len[w_win*CW +: CW];
          w_last_nxt       = w_win;
        end
      end
      RUN: begin
        if (clr) begin
          w_state_nxt = IDLE;
          w_gnt_nxt   = '0;
          w_count_nxt = '0;
          w_busy_nxt  = 1'b0;
        end else if (r_count == r_len_q) begin
          w_state_nxt = DONE;
          w_done_nxt  = 1'b1;
        end else begin
          w_count_nxt = r_count + 1'b1;
        end
      end
      // DONE always returns to IDLE; clr here has nothing extra to undo.
      default: begin
        w_state_nxt = IDLE;
        w_gnt_nxt   = '0;
        w_count_nxt = '0;
        w_busy_nxt  = 1'b0;
      end
    endcase
  end

  assign gnt   = r_gnt;
  assign count = r_count;
  assign busy  = r_busy;
  assign done  = r_done;

endmodule

// File: tb/tb_counter_arbiter.sv
// Bench for counter_arbiter: directed scenarios then random traffic, checked every cycle
// against a burst-offset reference model.
module tb_counter_arbiter;
  localparam int NREQ = 2;
  localparam int CW   = 4;

  logic               clk = 1'b0;
  logic               reset = 1'b0;
  logic [NREQ-1:0]    req = '0;
  logic [NREQ*CW-1:0] len = '0;
  logic               clr = 1'b0;
  logic [NREQ-1:0]    gnt;
  logic [CW-1:0]      count;
  logic               busy;
  logic               done;

  counter_arbiter #(.NREQ(NREQ), .CW(CW)) dut (
    .clk(clk), .reset(reset), .req(req), .len(len), .clr(clr),
    .gnt(gnt), .count(count), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  // Reference: a burst is described by the number of edges since its grant.
  bit m_active = 0;
  int m_off    = 0;
  int m_len    = 0;
  int m_owner  = 0;
  int m_last   = NREQ - 1;
  int m_dones  = 0;
  int o_dones  = 0;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_active = 0;
    m_last   = NREQ - 1;
  endtask

  task automatic model_edge();
    if (!reset) begin
      model_reset();
      return;
    end
    if (!m_active) begin
      for (int i = 1; i <= NREQ; i++) begin
        int k;
        k = (m_last + i) % NREQ;
        if (req[k]) begin
          m_owner  = k;
          m_last   = k;
          m_len    = int'(len[k*CW +: CW]);
          m_active = 1;
          m_off    = 1;
          break;
        end
      end
    end else if (clr) begin
      m_active = 0;
    end else begin
      m_off++;
      if (m_off == m_len + 3) m_active = 0;
    end
  endtask

  task automatic check_outputs();
    logic [NREQ-1:0] e_gnt;
    int e_count, e_busy, e_done;
    e_gnt = '0; e_count = 0; e_busy = 0; e_done = 0;
    if (m_active) begin
      e_gnt[m_owner] = 1'b1;
      e_busy = 1;
      if (m_off <= m_len + 1) e_count = m_off - 1;
      else begin
        e_count = m_len;
        e_done  = 1;
      end
    end
    m_dones += e_done;
    o_dones += (done === 1'b1) ? 1 : 0;
    chk("gnt",   32'(gnt),   32'(e_gnt));
    chk("count", 32'(count), 32'(e_count));
    chk("busy",  32'(busy),  32'(e_busy));
    chk("done",  32'(done),  32'(e_done));
  endtask

  task automatic step(int n = 1);
    repeat (n) begin
      @(posedge clk);
      model_edge();
      #1;
      check_outputs();
    end
  endtask

  task automatic set_len(int i, int v);
    len[i*CW +: CW] = CW'(v);
  endtask

  initial begin
    // Reset held for 5 cycles
    reset = 1'b0;
    #1;
    model_reset();
    check_outputs();
    step(5);
    reset = 1'b1;
    step(1);

    // Single burst, len0 = 3
    set_len(0, 3); req = 2'b01;
    step(1);
    req = 2'b00;
    step(7);

    // Round-robin with continuous requests
    set_len(0, 1); set_len(1, 2); req = 2'b11;
    m_dones = 0; o_dones = 0;
    step(18);
    chk("rr_done_total", 32'(o_dones), 32'd4);
    req = 2'b00;
    step(6);

    // Length extremes
    set_len(0, 0); req = 2'b01;
    step(1);
    req = 2'b00;
    step(4);
    set_len(0, 15); req = 2'b01;
    step(1);
    req = 2'b00;
    step(20);

    // Abort at count 2 of a len 5 burst; next grant rotates past aborted owner
    set_len(0, 5); set_len(1, 5); req = 2'b11;
    step(3);
    chk("abort_count_before", 32'(count), 32'd2);
    clr = 1'b1;
    step(1);
    clr = 1'b0;
    step(1);
    req = 2'b00;
    step(8);

    // Async reset mid-burst at count 4
    req = 2'b11;
    for (int t = 0; t < 20 && count !== CW'(4); t++) step(1);
    chk("pre_reset_count", 32'(count), 32'd4);
    #2;
    reset = 1'b0;
    #1;
    model_reset();
    check_outputs();
    step(2);
    reset = 1'b1;
    step(1);
    chk("post_reset_gnt", 32'(gnt), 32'd1);
    step(8);

    // Random traffic
    for (int t = 0; t < 1500; t++) begin
      req = NREQ'($urandom);
      for (int i = 0; i < NREQ; i++) begin
        case ($urandom_range(0, 3))
          0: set_len(i, 0);
          1: set_len(i, (1 << CW) - 1);
          default: set_len(i, int'($urandom_range(0, (1 << CW) - 1)));
        endcase
      end
      clr   = ($urandom_range(0, 9) == 0);
      reset = ($urandom_range(0, 99) != 0);
      step(1);
    end
    reset = 1'b1; clr = 1'b0; req = '0;
    step(20);
    chk("done_total", 32'(o_dones), 32'(m_dones));

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
